cell_pos_reader: RTL

CELL_POS_READER -- requirements
Module: cell_pos_reader

---
 rtl/cell_pos_reader_if.sv | 31 +++
 rtl/cell_pos_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cell_pos_reader_if.sv
// Cell memory read port and particle output stream.
// master: the reader (drives memory requests, sources particles).
// slave:  the environment (returns memory data, consumes particles).
interface cell_pos_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  particle_valid;
    logic                  particle_ready;
    logic [DATA_WIDTH-1:0] particle_pos;
    logic [ADDR_WIDTH-1:0] particle_id;
    logic                  particle_last;

    modport master (
        output mem_address, mem_rden, mem_wren,
        input  mem_q,
        output particle_valid, particle_pos, particle_id, particle_last,
        input  particle_ready
    );

    modport slave (
        input  mem_address, mem_rden, mem_wren,
        output mem_q,
        input  particle_valid, particle_pos, particle_id, particle_last,
        output particle_ready
    );
endinterface

// File: rtl/cell_pos_reader.sv
// Streams the particle positions of one cell out of the cell memory.
// Address 0 holds the particle count N; addresses 1..N hold packed {posz, posy, posx}.
// Reads are credit-limited so in-flight reads plus buffered words never exceed 4.
// Optional macro CELL_READ_STALL_CNT_EN builds the backpressure stall counter.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    cell_pos_reader_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   count_err,
    output logic [15:0]            stall_count
);

    localparam logic [ADDR_WIDTH-1:0] MaxN = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {
        StIdle, StRdCnt, StWaitCnt, StStream, StDrain, StFinish
    } state_t;

    state_t                state_q;
    logic                  wait_q;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic                  rden_q;
    logic                  done_q;
    logic                  cerr_q;

    // Read-return pipeline matching the 2-cycle memory latency.
    logic                  vld1_q, vld2_q;
    logic [ADDR_WIDTH-1:0] id1_q, id2_q;

    // 4-entry output FIFO.
    logic [DATA_WIDTH-1:0] pos_mem [4];
    logic [ADDR_WIDTH-1:0] id_mem  [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            cnt_q;

    logic                  rd_part;
    logic                  push, pop;
    logic [3:0]            occ;
    logic                  can_issue;
    logic [ADDR_WIDTH-1:0] cnt_raw, n_new, next_addr, head_id;
    logic                  over;

    // The count read (issued in StRdCnt) must not land in the FIFO.
    assign rd_part   = rden_q && (state_q != StRdCnt);
    assign push      = vld2_q;
    assign pop       = (cnt_q != 3'd0) && bus.particle_ready;
    // Outstanding words after this cycle's pop; a pop frees a slot for a same-cycle issue.
    assign occ       = 4'(rd_part) + 4'(vld1_q) + 4'(vld2_q) + 4'(cnt_q) - 4'(pop);
    assign can_issue = occ < 4'd4;
    assign cnt_raw   = bus.mem_q[ADDR_WIDTH-1:0];
    assign over      = cnt_raw > MaxN;
    assign n_new     = over ? MaxN : cnt_raw;
    assign next_addr = addr_q + 1'b1;
    assign head_id   = id_mem[rd_ptr_q];

    // Control FSM with registered memory-request and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wait_q  <= 1'b0;
            n_q     <= '0;
            addr_q  <= '0;
            maddr_q <= '0;
            rden_q  <= 1'b0;
            done_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            rden_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRdCnt;
                        rden_q  <= 1'b1;
                        maddr_q <= '0;
                        cerr_q  <= 1'b0;
                    end
                end
                StRdCnt: begin
                    state_q <= StWaitCnt;
                    wait_q  <= 1'b0;
                end
                StWaitCnt: begin
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else begin
                        n_q    <= n_new;
                        cerr_q <= over;
                        if (n_new == '0) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            // Pipeline is empty here, so address 1 can always go out.
                            rden_q  <= 1'b1;
                            maddr_q <= ADDR_WIDTH'(1);
                            addr_q  <= ADDR_WIDTH'(1);
                            state_q <= (n_new == ADDR_WIDTH'(1)) ? StDrain : StStream;
                        end
                    end
                end
                StStream: begin
                    if (can_issue) begin
                        rden_q  <= 1'b1;
                        maddr_q <= next_addr;
                        addr_q  <= next_addr;
                        if (next_addr == n_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && (head_id == n_q)) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Return pipeline and FIFO pointers; reset drops any data still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            id1_q    <= '0;
            id2_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld1_q <= rd_part;
            id1_q  <= maddr_q;
            vld2_q <= vld1_q;
            id2_q  <= id1_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            cnt_q <= cnt_q + 3'(push) - 3'(pop);
        end
    end

    // FIFO storage; entries are qualified by the occupancy count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pos_mem[wr_ptr_q] <= bus.mem_q;
            id_mem[wr_ptr_q]  <= id2_q;
        end
    end

`ifdef CELL_READ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the head word waits on downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start && (state_q == StIdle)) begin
            stall_q <= '0;
        end else if (bus.particle_valid && !bus.particle_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

    assign bus.mem_address    = maddr_q;
    assign bus.mem_rden       = rden_q;
    assign bus.mem_wren       = 1'b0;
    assign bus.particle_valid = (cnt_q != 3'd0);
    assign bus.particle_pos   = bus.particle_valid ? pos_mem[rd_ptr_q] : '0;
    assign bus.particle_id    = bus.particle_valid ? head_id : '0;
    assign bus.particle_last  = bus.particle_valid && (head_id == n_q);
    assign busy               = (state_q != StIdle);
    assign done               = done_q;
    assign count_err          = cerr_q;

endmodule
